// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU
// memory stage and the host port.
package dmem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic {
    CPU_PRIO   = 1'b0,
    HOST_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Host starvation counter: counts denied host cycles, saturates at all-ones,
// and flags when the value about to be stored reaches STARVE_MAX.
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_cnt;
  logic [STARVE_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign o_hit = (w_cnt_nxt == MAX_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM between the CPU memory stage (default
// priority) and the host port, with a forced host slot after bounded starvation.
//
// state      | meaning
// CPU_PRIO   | CPU wins any request; host granted only when CPU is idle
// HOST_FORCE | one-cycle host slot, CPU stalled regardless of its request
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  owner_t     r_rd_owner;
  owner_t     w_rd_owner_nxt;

  logic w_cpu_gnt;
  logic w_host_gnt;
  logic w_hit;
  logic w_cnt_clr;
  logic w_cnt_inc;

  // Leaving HOST_FORCE always clears, covering a host that withdrew its request.
  assign w_cnt_clr = w_host_gnt | (r_state == HOST_FORCE);
  assign w_cnt_inc = host_req & ~w_host_gnt;

  starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_hit (w_hit)
  );

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_host_gnt  = 1'b0;
    w_state_nxt = r_state;
    if (!rst) begin
      case (r_state)
        CPU_PRIO: begin
          if (cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else if (host_req) begin
            w_host_gnt = 1'b1;
          end
          if (w_hit) begin
            w_state_nxt = HOST_FORCE;
          end
        end
        HOST_FORCE: begin
          w_host_gnt  = host_req;
          w_state_nxt = CPU_PRIO;
        end
        default: w_state_nxt = CPU_PRIO;
      endcase
    end
  end

  always_comb begin
    mem_wen        = 1'b0;
    mem_ren        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    w_rd_owner_nxt = OWN_NONE;
    if (w_cpu_gnt) begin
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_wen) begin
        w_rd_owner_nxt = OWN_CPU;
      end
    end else if (w_host_gnt) begin
      mem_wen   = host_wen;
      mem_ren   = ~host_wen;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      if (!host_wen) begin
        w_rd_owner_nxt = OWN_HOST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CPU_PRIO;
      r_rd_owner <= OWN_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_owner <= w_rd_owner_nxt;
    end
  end

  assign cpu_gnt     = w_cpu_gnt;
  assign host_gnt    = w_host_gnt;
  assign cpu_stall   = cpu_req & ~w_cpu_gnt;
  assign cpu_rvalid  = (r_rd_owner == OWN_CPU);
  assign host_rvalid = (r_rd_owner == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural arbiter/memory model predicts
// grants and read data; a separate monitor checks read returns.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_wen, host_req, host_wen;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic          cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid;
  logic          mem_ren, mem_wen;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'h5A5A_0F0F ^ (32'(a) * 32'h0100_0193);
  endfunction

  // SRAM: write-then-read, read data one cycle after mem_ren
  bit            sram_ready = 1'b0;
  logic [DW-1:0] sram [0:1023];
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
      sram_ready <= 1'b1;
    end else begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          q_cpu[$];
  exp_t          q_host[$];
  logic [DW-1:0] shadow [0:1023];
  int            m_wait;
  bit            m_forced;

  // Monitor: a read expected from an earlier cycle must appear now, else outputs idle
  always @(negedge clk) begin
    if (q_cpu.size() > 0 && q_cpu[0].c < cyc) begin
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'd1);
      chk("cpu_rdata", 64'(cpu_rdata), 64'(q_cpu[0].d));
      void'(q_cpu.pop_front());
    end else begin
      chk("cpu_rvalid_idle", 64'(cpu_rvalid), 64'd0);
      chk("cpu_rdata_idle", 64'(cpu_rdata), 64'd0);
    end
    if (q_host.size() > 0 && q_host[0].c < cyc) begin
      chk("host_rvalid", 64'(host_rvalid), 64'd1);
      chk("host_rdata", 64'(host_rdata), 64'(q_host[0].d));
      void'(q_host.pop_front());
    end else begin
      chk("host_rvalid_idle", 64'(host_rvalid), 64'd0);
      chk("host_rdata_idle", 64'(host_rdata), 64'd0);
    end
  end

  // One cycle: drive inputs, check against the model at negedge, advance the model.
  task automatic step(input bit r,
                      input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit hr, input bit hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                      output bit cg, output bit hg);
    bit            e_wen, e_ren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    rst = r;
    cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_wen = hw; host_addr = ha; host_wdata = hd;
    @(negedge clk);
    cg = !r && !m_forced && cr;
    hg = !r && (m_forced ? hr : (!cr && hr));
    e_wen = 1'b0; e_ren = 1'b0; e_addr = '0; e_wdata = '0;
    if (cg) begin
      e_wen = cw; e_ren = !cw; e_addr = ca; e_wdata = cd;
    end else if (hg) begin
      e_wen = hw; e_ren = !hw; e_addr = ha; e_wdata = hd;
    end
    if (!r) chk("starve_cnt", 64'(dut.u_starve.r_cnt), 64'(m_wait));
    chk("cpu_gnt", 64'(cpu_gnt), 64'(cg));
    chk("host_gnt", 64'(host_gnt), 64'(hg));
    chk("cpu_stall", 64'(cpu_stall), 64'(cr && !cg));
    chk("mem_wen", 64'(mem_wen), 64'(e_wen));
    chk("mem_ren", 64'(mem_ren), 64'(e_ren));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    if (cg) begin
      if (cw) shadow[ca] = cd;
      else q_cpu.push_back('{d: shadow[ca], c: cyc});
    end else if (hg) begin
      if (hw) shadow[ha] = hd;
      else q_host.push_back('{d: shadow[ha], c: cyc});
    end
    if (r || m_forced || hg) begin
      m_forced = 1'b0;
      m_wait   = 0;
    end else if (hr) begin
      m_wait++;
      if (m_wait == SM) m_forced = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  bit            cg, hg, cp, hp, pcw, phw;
  logic [AW-1:0] pca, pha;
  logic [DW-1:0] pcd, phd;

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    m_wait = 0;
    m_forced = 1'b0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_wen = 1'b0; host_addr = '0; host_wdata = '0;
    @(posedge clk);
    #1;
    // reset with both requesting, then CPU read of addr 5
    step(1, 1, 0, 10'd5, '0, 1, 0, 10'd7, '0, cg, hg);
    step(1, 1, 0, 10'd5, '0, 1, 0, 10'd7, '0, cg, hg);
    step(0, 1, 0, 10'd5, '0, 0, 0, '0, '0, cg, hg);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, cg, hg);
    // host-only write then read back
    step(0, 0, 0, '0, '0, 1, 1, 10'd3, 32'hDEAD_BEEF, cg, hg);
    step(0, 0, 0, '0, '0, 1, 0, 10'd3, '0, cg, hg);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, cg, hg);
    // continuous contention: CPU reads addr 1, host reads addr 2 in forced slots
    for (int i = 0; i < 15; i++) step(0, 1, 0, 10'd1, '0, 1, 0, 10'd2, '0, cg, hg);
    // host withdraws during the forced slot
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, cg, hg);
    for (int i = 0; i < SM; i++) step(0, 1, 0, 10'd4, '0, 1, 0, 10'd6, '0, cg, hg);
    step(0, 1, 0, 10'd4, '0, 0, 0, '0, '0, cg, hg);
    step(0, 1, 0, 10'd4, '0, 0, 0, '0, '0, cg, hg);
    // reset on the cycle of a CPU read
    step(1, 1, 0, 10'd9, '0, 0, 0, '0, '0, cg, hg);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, cg, hg);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, cg, hg);
    // randomized traffic with held requests, occasional withdraw and reset
    cp = 1'b0; hp = 1'b0;
    pcw = 1'b0; phw = 1'b0; pca = '0; pha = '0; pcd = '0; phd = '0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      if (!cp && $urandom_range(0, 99) < 70) begin
        cp = 1'b1; pcw = ($urandom_range(0, 2) == 0);
        pca = AW'($urandom_range(0, 15)); pcd = $urandom;
      end
      if (!hp && $urandom_range(0, 99) < 50) begin
        hp = 1'b1; phw = ($urandom_range(0, 2) == 0);
        pha = AW'($urandom_range(0, 15)); phd = $urandom;
      end
      if (hp && m_forced && $urandom_range(0, 3) == 0) hp = 1'b0;
      r = ($urandom_range(0, 199) == 0);
      step(r, cp, pcw, pca, pcd, hp, phw, pha, phd, cg, hg);
      if (cg) cp = 1'b0;
      if (hg) hp = 1'b0;
    end
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, cg, hg);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, cg, hg);
    chk("queue_drain", 64'(q_cpu.size() + q_host.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
